// File: rtl/axis2fifo_pkg.sv
// axis2fifo_pkg
// Shared definitions for the pixel packer and the frame-to-memory writer.
// It provides the pixel slot sizing, the pixels-per-word derivation and
// the packer state encoding. It has no ports.

package axis2fifo_pkg;

    // SYNC waits for a start-of-frame beat, RUN packs pixels, and DRAIN
    // holds off the stream until the final word of the frame is written.
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } a2f_state_t;

    // Each pixel occupies a byte-aligned slot of 1, 2 or 4 bytes.
    function automatic int pixel_bytes(input int pixel_width);
        if (pixel_width <= 8)
            return 1;
        else if (pixel_width <= 16)
            return 2;
        else
            return 4;
    endfunction

    // Number of pixel slots in one memory word.
    function automatic int adata_pixels(input int data_width, input int pixel_width);
        return data_width / 8 / pixel_bytes(pixel_width);
    endfunction

endpackage

// File: rtl/axis2fifo_if.sv
// axis2fifo_if
// Groups the pixel stream and the FIFO write side of the packer.
//   s_axis_tvalid/tdata/tuser/tlast : pixel stream into the packer
//   s_axis_tready                   : packer accepts the current beat
//   fifo_din/fifo_sof/fifo_wr_en    : packed word, first-of-frame flag, strobe
//   fifo_full                       : FIFO back-pressure
// The slave modport is the packer; the master modport is the surrounding
// source/sink logic.

interface axis2fifo_if #(
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_PIXEL_WIDTH = 8
);
    logic                     s_axis_tvalid;
    logic [C_PIXEL_WIDTH-1:0] s_axis_tdata;
    logic                     s_axis_tuser;
    logic                     s_axis_tlast;
    logic                     s_axis_tready;
    logic [C_DATA_WIDTH-1:0]  fifo_din;
    logic                     fifo_sof;
    logic                     fifo_wr_en;
    logic                     fifo_full;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast, fifo_full,
        output s_axis_tready, fifo_din, fifo_sof, fifo_wr_en
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tuser, s_axis_tlast, fifo_full,
        input  s_axis_tready, fifo_din, fifo_sof, fifo_wr_en
    );
endinterface

// File: rtl/axis2fifo_pack.sv
// axis2fifo_pack
// Lane register plus lane counter that gathers pixels into one memory word.
//   clk, reset : clock and synchronous active-high reset
//   clear      : discard the partial word (wins over push)
//   push       : accept 'pixel' into the next free slot
//   restart    : 'pixel' is slot 0 of a fresh word; any partial word is dropped
//   word, done : assembled word and completion flag for the current push

module axis2fifo_pack
    import axis2fifo_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_PIXEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     restart,
    input  logic [C_PIXEL_WIDTH-1:0] pixel,
    output logic [C_DATA_WIDTH-1:0]  word,
    output logic                     done
);

    localparam int SLOT_BITS = 8 * pixel_bytes(C_PIXEL_WIDTH);
    localparam int NPIX      = adata_pixels(C_DATA_WIDTH, C_PIXEL_WIDTH);
    localparam int CNT_BITS  = (NPIX > 1) ? $clog2(NPIX) : 1;

    logic [C_DATA_WIDTH-1:0] lanes;
    logic [C_DATA_WIDTH-1:0] base_lanes;
    logic [CNT_BITS-1:0]     lane_cnt;
    logic [CNT_BITS-1:0]     base_cnt;

    // Merge the incoming pixel into its slot. On restart the pixel is
    // treated as slot 0 of an empty word, so a resync beat never inherits
    // stale lanes. Unused slot bits stay zero because lanes start cleared.
    always_comb begin
        base_lanes = restart ? '0 : lanes;
        base_cnt   = restart ? '0 : lane_cnt;
        word       = base_lanes | (C_DATA_WIDTH'(pixel) << (SLOT_BITS * int'(base_cnt)));
        done       = push && (int'(base_cnt) == NPIX - 1);
    end

    // Once a word completes it is handed out through 'word', and the lanes
    // restart empty for the next pixel.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lanes    <= '0;
            lane_cnt <= '0;
        end else if (push) begin
            if (done) begin
                lanes    <= '0;
                lane_cnt <= '0;
            end else begin
                lanes    <= word;
                lane_cnt <= base_cnt + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/axis2fifo.sv
// axis2fifo
// Packs an AXI4-Stream pixel stream into memory-width words for the frame
// writer's FIFO. The first word of each frame carries sof. The block checks
// line and frame geometry and resynchronises on the next tuser after an
// error or a soft reset.
//   clk, reset            : clock and synchronous active-high reset
//   soft_reset            : writer-driven resync; clears state like reset
//   img_width, img_height : frame geometry (pixels per line, lines)
//   bus                   : pixel stream in, FIFO write side out
//   frame_done            : pulses with the write of a frame's last word
//   err_short_line        : pulse, tlast arrived before the last column
//   err_long_line         : pulse, no tlast at the last column
//   err_early_sof         : pulse, tuser arrived mid-frame

module axis2fifo
    import axis2fifo_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   soft_reset,
    input  logic [C_IMG_WBITS-1:0] img_width,
    input  logic [C_IMG_HBITS-1:0] img_height,
    axis2fifo_if.slave             bus,
    output logic                   frame_done,
    output logic                   err_short_line,
    output logic                   err_long_line,
    output logic                   err_early_sof
);

    localparam int NPIX = adata_pixels(C_DATA_WIDTH, C_PIXEL_WIDTH);

    a2f_state_t state, state_n;

    logic [C_IMG_WBITS-1:0]  col, col_n, cur_col;
    logic [C_IMG_HBITS-1:0]  row, row_n, cur_row;
    logic                    sof_pending, sof_cur;
    logic                    out_valid, wr_en, tready, in_reset;
    logic                    accept, start, in_frame, line_err;
    logic                    short_n, long_n, early_n;
    logic                    pack_push, pack_restart, pack_clear, pack_done;
    logic [C_DATA_WIDTH-1:0] pack_word;

    assign in_reset = reset | soft_reset;

    // Handshake. A pending word is written whenever the FIFO has room. In
    // RUN a new beat is accepted only if that write frees the output
    // register, which gives one pixel per cycle without losing data. In
    // SYNC a single beat cannot complete a word unless a word is one pixel
    // wide, so only that case needs the same guard.
    always_comb begin
        wr_en = out_valid & ~bus.fifo_full & ~in_reset;
        case (state)
            ST_SYNC: tready = (NPIX > 1) | ~out_valid | ~bus.fifo_full;
            ST_RUN:  tready = ~out_valid | ~bus.fifo_full;
            default: tready = 1'b0;
        endcase
        if (in_reset)
            tready = 1'b0;
    end

    assign bus.s_axis_tready = tready;
    assign bus.fifo_wr_en    = wr_en;
    assign frame_done        = (state == ST_DRAIN) & wr_en;
    assign accept            = bus.s_axis_tvalid & tready;

    // Next-state and column/row bookkeeping. A tuser beat in SYNC or RUN
    // starts a frame, and the beat is checked as column img_width-1 of row
    // img_height-1. 'col' and 'row' always hold the countdown for the next
    // beat, so the current beat uses cur_col/cur_row.
    always_comb begin
        state_n      = state;
        col_n        = col;
        row_n        = row;
        pack_push    = 1'b0;
        pack_restart = 1'b0;
        pack_clear   = 1'b0;
        short_n      = 1'b0;
        long_n       = 1'b0;
        early_n      = 1'b0;

        start    = accept && bus.s_axis_tuser && (state == ST_SYNC || state == ST_RUN);
        in_frame = accept && ((state == ST_RUN) || start);
        cur_col  = start ? (img_width - C_IMG_WBITS'(1)) : col;
        cur_row  = start ? (img_height - C_IMG_HBITS'(1)) : row;
        sof_cur  = start ? 1'b1 : sof_pending;
        line_err = 1'b0;

        if (accept && bus.s_axis_tuser && state == ST_RUN)
            early_n = 1'b1;

        case (state)
            ST_SYNC, ST_RUN: begin
                if (in_frame) begin
                    if (cur_col == '0 && !bus.s_axis_tlast) begin
                        long_n   = 1'b1;
                        line_err = 1'b1;
                    end else if (cur_col != '0 && bus.s_axis_tlast) begin
                        short_n  = 1'b1;
                        line_err = 1'b1;
                    end

                    if (line_err) begin
                        pack_clear = 1'b1;
                        state_n    = ST_SYNC;
                    end else begin
                        pack_push    = 1'b1;
                        pack_restart = start;
                        state_n      = ST_RUN;
                        if (cur_col == '0) begin
                            if (cur_row == '0) begin
                                state_n = ST_DRAIN;
                            end else begin
                                col_n = img_width - C_IMG_WBITS'(1);
                                row_n = cur_row - C_IMG_HBITS'(1);
                            end
                        end else begin
                            col_n = cur_col - C_IMG_WBITS'(1);
                            row_n = cur_row;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_en)
                    state_n = ST_SYNC;
            end
            default: state_n = ST_SYNC;
        endcase
    end

    axis2fifo_pack #(
        .C_DATA_WIDTH  (C_DATA_WIDTH),
        .C_PIXEL_WIDTH (C_PIXEL_WIDTH)
    ) u_pack (
        .clk     (clk),
        .reset   (reset),
        .clear   (soft_reset | pack_clear),
        .push    (pack_push),
        .restart (pack_restart),
        .pixel   (bus.s_axis_tdata),
        .word    (pack_word),
        .done    (pack_done)
    );

    // State, counters, output register and error pulses. A completed word
    // can only land when the output register is empty or being written in
    // the same cycle, so out_valid never drops a word.
    always_ff @(posedge clk) begin
        if (in_reset) begin
            state          <= ST_SYNC;
            col            <= '0;
            row            <= '0;
            sof_pending    <= 1'b0;
            out_valid      <= 1'b0;
            bus.fifo_din   <= '0;
            bus.fifo_sof   <= 1'b0;
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
            err_early_sof  <= 1'b0;
        end else begin
            state          <= state_n;
            col            <= col_n;
            row            <= row_n;
            out_valid      <= (out_valid & ~wr_en) | pack_done;
            err_short_line <= short_n;
            err_long_line  <= long_n;
            err_early_sof  <= early_n;
            if (pack_push)
                sof_pending <= pack_done ? 1'b0 : sof_cur;
            else if (pack_clear)
                sof_pending <= 1'b0;
            if (pack_done) begin
                bus.fifo_din <= pack_word;
                bus.fifo_sof <= sof_cur;
            end
        end
    end

endmodule

// File: tb/tb_axis2fifo.sv
// tb_axis2fifo
// Directed bench for axis2fifo using an 8x2 frame of 8-bit pixels packed
// four per 32-bit word. A negedge monitor captures every FIFO write as
// {frame_done, fifo_sof, fifo_din}, and the linear sequence compares those
// captures and the handshake/pulse outputs against hand-computed values.

module tb_axis2fifo;

    logic        clk;
    logic        reset;
    logic        soft_reset;
    logic [11:0] img_width;
    logic [11:0] img_height;
    logic        frame_done;
    logic        err_short_line;
    logic        err_long_line;
    logic        err_early_sof;

    int          vectors = 0;
    int          miscompares = 0;
    int          full_cnt = 0;
    logic [33:0] wq[$];

    // Expected writes of one 8x2 frame of pixels 0x00..0x0F: {frame_done, sof, word}.
    logic [33:0] exp_frame[4] = '{34'h1_03020100, 34'h0_07060504,
                                  34'h0_0B0A0908, 34'h2_0F0E0D0C};

    axis2fifo_if #(.C_DATA_WIDTH(32), .C_PIXEL_WIDTH(8)) bus ();

    axis2fifo #(
        .C_DATA_WIDTH  (32),
        .C_PIXEL_WIDTH (8),
        .C_IMG_WBITS   (12),
        .C_IMG_HBITS   (12)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .soft_reset     (soft_reset),
        .img_width      (img_width),
        .img_height     (img_height),
        .bus            (bus),
        .frame_done     (frame_done),
        .err_short_line (err_short_line),
        .err_long_line  (err_long_line),
        .err_early_sof  (err_early_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every FIFO write mid-cycle, together with the frame_done flag.
    always @(negedge clk) begin
        if (bus.fifo_wr_en === 1'b1)
            wq.push_back({frame_done, bus.fifo_sof, bus.fifo_din});
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and age the fifo_full hold counter.
    task automatic tick();
        @(posedge clk);
        #1;
        if (full_cnt > 0) begin
            full_cnt--;
            bus.fifo_full = (full_cnt > 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Present one beat and hold it until accepted, with a bounded wait.
    task automatic applyStimulus(input logic [7:0] data, input logic user, input logic last);
        logic got;
        int   guard;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = data;
        bus.s_axis_tuser  = user;
        bus.s_axis_tlast  = last;
        got   = 1'b0;
        guard = 0;
        while (!got && guard < 64) begin
            @(negedge clk);
            got = (bus.s_axis_tready === 1'b1);
            tick();
            guard++;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        if (!got)
            checkOutput("beat_timeout", {63'd0, got}, 64'd1);
    endtask

    // Pixels from..to of the 8x2 frame: pixel value = index, tuser on 0,
    // tlast on 7 and 15.
    task automatic sendRange(input int from, input int to);
        for (int p = from; p <= to; p++)
            applyStimulus(8'(p), p == 0, (p == 7) || (p == 15));
    endtask

    task automatic checkFrame(input string tag);
        logic [33:0] obs;
        checkOutput({tag, "_count"}, 64'(wq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            obs = (i < wq.size()) ? wq[i] : '1;
            checkOutput($sformatf("%s_w%0d", tag, i), 64'(obs), 64'(exp_frame[i]));
        end
        wq.delete();
    endtask

    task automatic checkWord0Only(input string tag);
        logic [33:0] obs;
        checkOutput({tag, "_count"}, 64'(wq.size()), 64'd1);
        obs = (wq.size() > 0) ? wq[0] : '1;
        checkOutput({tag, "_word0"}, 64'(obs), 64'h1_03020100);
        wq.delete();
    endtask

    initial begin
        reset             = 1'b1;
        soft_reset        = 1'b0;
        img_width         = 12'd8;
        img_height        = 12'd2;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 8'h00;
        bus.s_axis_tuser  = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.fifo_full     = 1'b0;

        // Reset: all outputs quiet, tready low.
        idle(3);
        @(negedge clk);
        checkOutput("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        checkOutput("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
        checkOutput("rst_errs", 64'({err_short_line, err_long_line, err_early_sof}), 64'd0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("sync_tready", 64'(bus.s_axis_tready), 64'd1);
        tick();

        // Scenario 1: a clean frame, with latency and drain timing probed.
        $display("[TB] scenario 1: clean 8x2 frame");
        for (int p = 0; p <= 15; p++) begin
            applyStimulus(8'(p), p == 0, (p == 7) || (p == 15));
            if (p == 3) begin
                @(negedge clk);
                checkOutput("s1_latency_wr", 64'(bus.fifo_wr_en), 64'd1);
                checkOutput("s1_latency_word", 64'({bus.fifo_sof, bus.fifo_din}), 64'h1_03020100);
                tick();
            end
            if (p == 15) begin
                @(negedge clk);
                checkOutput("s1_drain_tready", 64'(bus.s_axis_tready), 64'd0);
                checkOutput("s1_drain_wr", 64'(bus.fifo_wr_en), 64'd1);
                checkOutput("s1_frame_done", 64'(frame_done), 64'd1);
                tick();
            end
        end
        idle(3);
        checkFrame("s1");

        // Scenario 2: FIFO full for 5 cycles after the first word goes out.
        $display("[TB] scenario 2: back-pressure");
        sendRange(0, 4);
        full_cnt      = 5;
        bus.fifo_full = 1'b1;
        sendRange(5, 7);
        @(negedge clk);
        checkOutput("s2_stall_tready", 64'(bus.s_axis_tready), 64'd0);
        checkOutput("s2_stall_wr", 64'(bus.fifo_wr_en), 64'd0);
        tick();
        sendRange(8, 15);
        idle(3);
        checkFrame("s2");

        // Scenario 3: beats before any tuser are dropped.
        $display("[TB] scenario 3: pre-sync beats");
        for (int i = 0; i < 6; i++)
            applyStimulus(8'hA0 + 8'(i), 1'b0, i == 5);
        idle(2);
        checkOutput("s3_no_writes", 64'(wq.size()), 64'd0);
        sendRange(0, 15);
        idle(3);
        checkFrame("s3");

        // Scenario 4: tlast on pixel 5 of an 8-wide line.
        $display("[TB] scenario 4: short line");
        sendRange(0, 4);
        applyStimulus(8'h05, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("s4_err_short", 64'(err_short_line), 64'd1);
        checkOutput("s4_err_long", 64'(err_long_line), 64'd0);
        tick();
        idle(3);
        checkWord0Only("s4");
        sendRange(0, 15);
        idle(3);
        checkFrame("s4_recover");

        // Scenario 5: pixel 7 without tlast, then junk, then a good frame.
        $display("[TB] scenario 5: long line");
        sendRange(0, 6);
        applyStimulus(8'h07, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("s5_err_long", 64'(err_long_line), 64'd1);
        checkOutput("s5_err_short", 64'(err_short_line), 64'd0);
        tick();
        applyStimulus(8'h08, 1'b0, 1'b0);
        applyStimulus(8'h09, 1'b0, 1'b1);
        idle(3);
        checkWord0Only("s5");
        sendRange(0, 15);
        idle(3);
        checkFrame("s5_recover");

        // Scenario 6: a tuser three pixels into a frame restarts the frame.
        $display("[TB] scenario 6: early sof");
        applyStimulus(8'h50, 1'b1, 1'b0);
        applyStimulus(8'h51, 1'b0, 1'b0);
        applyStimulus(8'h52, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("s6_err_early", 64'(err_early_sof), 64'd1);
        tick();
        sendRange(1, 15);
        idle(3);
        checkFrame("s6");

        // Scenario 7: soft reset for two cycles after pixel 5.
        $display("[TB] scenario 7: soft reset");
        sendRange(0, 5);
        soft_reset = 1'b1;
        @(negedge clk);
        checkOutput("s7_soft_tready", 64'(bus.s_axis_tready), 64'd0);
        tick();
        tick();
        soft_reset = 1'b0;
        idle(3);
        checkWord0Only("s7");
        sendRange(0, 15);
        idle(3);
        checkFrame("s7_recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis2fifo.md
# axis2fifo

Upstream feeder for the frame-to-memory writer. It accepts an AXI4-Stream video pixel stream (tuser = start of frame, tlast = end of line) and packs pixels into memory-width words. It writes those words into the FIFO the writer drains, and flags the first word of each frame with a sof bit. It enforces frame geometry and resynchronises to the next tuser after any error or soft reset, so the writer only ever sees whole, aligned frames.

## Interface
- C_DATA_WIDTH, 32, FIFO/memory word width; multiple of 8.
- C_PIXEL_WIDTH, 8, pixel bits; each pixel occupies a slot of C_PIXEL_BYTES bytes (1 if ≤8, 2 if ≤16, else 4).
- C_IMG_WBITS, 12, width counter bits.
- C_IMG_HBITS, 12, height counter bits.
- Derived: C_ADATA_PIXELS = C_DATA_WIDTH/8/C_PIXEL_BYTES pixels per word.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- soft_reset  in  1  active-high; driven by the writer's resetting output.
- img_width  in  C_IMG_WBITS  pixels per line; multiple of C_ADATA_PIXELS, nonzero.
- img_height  in  C_IMG_HBITS  lines per frame, nonzero.
- s_axis_tvalid  in  1  pixel valid.
- s_axis_tdata  in  C_PIXEL_WIDTH  pixel.
- s_axis_tuser  in  1  first pixel of frame.
- s_axis_tlast  in  1  last pixel of line.
- s_axis_tready  out  1  pixel accepted when tvalid & tready.
- fifo_din  out  C_DATA_WIDTH  packed word.
- fifo_sof  out  1  word is first of frame; written alongside fifo_din.
- fifo_wr_en  out  1  write strobe.
- fifo_full  in  1  FIFO cannot accept.
- frame_done  out  1  one-cycle pulse when the last word of a frame is written.
- err_short_line  out  1  one-cycle pulse: tlast before the last column.
- err_long_line  out  1  one-cycle pulse: no tlast at the last column.
- err_early_sof  out  1  one-cycle pulse: tuser mid-frame.

## Operation
- States: SYNC (wait for tuser), RUN, DRAIN (last word pending).
- SYNC: tready=1 and non-tuser beats are discarded. A tuser beat is taken as pixel 0: load col = img_width-1 and row = img_height-1, set sof_pending, enter RUN.
- Packing: pixel k of a word goes to bits [k·8·C_PIXEL_BYTES +: C_PIXEL_WIDTH]; unused slot bits are 0; first pixel in the LSBs. When lane count reaches C_ADATA_PIXELS, the word moves to the output register (out_valid) with fifo_sof = sof_pending, and sof_pending clears.
- Column check on each accepted beat:
  - col==0 with tlast clear → err_long_line.
  - col≠0 with tlast set → err_short_line.
  - On either error: discard the partial word, go to SYNC. A queued out_valid word is still written.
- On col==0 with tlast: if row==0, go to DRAIN, else reload col and decrement row.
- err_early_sof: tuser while in RUN. Discard the partial word, pulse, restart as if in SYNC with this beat as pixel 0.
- DRAIN: tready=0. When the final word is written, pulse frame_done and go to SYNC.
- soft_reset or reset: clear out_valid, lanes, sof_pending and counters; go to SYNC. All outputs are 0 during reset; tready=0 while reset or soft_reset is high.

## Timing
- fifo_wr_en = out_valid & ~fifo_full; fifo_din and fifo_sof are registered.
- Latency: the beat completing a word is accepted in cycle N; the word is presented in cycle N+1.
- s_axis_tready in RUN = ~out_valid | ~fifo_full. A write and the completion of a new word in the same cycle are legal, giving full throughput at one pixel per cycle.
- fifo_full held: out_valid holds, and tready drops only once a word is pending. No data loss or reordering.
- frame_done pulses in the same cycle as the fifo_wr_en of the last word.
- Error pulses are asserted the cycle after the offending beat is accepted.

## Structure
- Shared package: pixel-bytes function, C_ADATA_PIXELS derivation, state encoding; shared with the writer.
- One sub-module: axis2fifo_pack (lane shift register plus lane counter, emits word + done).

## Test plan
- Frame 8×2, 8-bit pixels 0x00–0x0F, tlast at columns 7/15, tuser on the first beat → 4 writes: 0x03020100 (sof=1), 0x07060504, 0x0B0A0908, 0x0F0E0D0C; frame_done with the 4th write.
- Same frame with fifo_full high for 5 cycles after word 1 → tready low while a word is pending; the same 4 words arrive in order.
- 6 beats without tuser, then a valid frame → the first 6 are dropped; output is identical to scenario 1.
- Width 8, tlast on pixel 5 → err_short_line; only word 0 is written; the next tuser frame is correct.
- Width 8, no tlast on pixel 7 → err_long_line; sync is recovered on the next tuser.
- soft_reset for 2 cycles after pixel 5 → no further writes; after release the next tuser frame produces 0x03020100 with sof=1.
